// File: rtl/async_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : async_fifo_pkg
// Description : Shared constants and Gray/binary conversion helpers for the
//               dual-clock FIFO. The helpers work on a c_MAX_W-bit container;
//               callers zero-extend narrower values and truncate the result.
//               Leading zeros leave both conversions unchanged, so one
//               function serves every pointer width.
// Revision    : 1.0 - initial release
// ============================================================================
package async_fifo_pkg;

    localparam int c_DEFAULT_ASIZE = 4;
    localparam int c_MAX_W         = 32;

    function automatic logic [c_MAX_W-1:0] bin2gray(input logic [c_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits from the MSB down to it.
    function automatic logic [c_MAX_W-1:0] gray2bin(input logic [c_MAX_W-1:0] g);
        logic [c_MAX_W-1:0] b;
        b[c_MAX_W-1] = g[c_MAX_W-1];
        for (int i = c_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_r2w.sv
`default_nettype none
// ============================================================================
// Module      : sync_r2w
// Description : Two-flop synchronizer bringing the read-domain Gray pointer
//               into the write clock domain.
// Ports       : wclk     - write clock
//               wrst_n   - asynchronous active-low reset
//               rptr     - Gray read pointer (asynchronous to wclk)
//               wq2_rptr - synchronized Gray read pointer
// Revision    : 1.0 - initial release
// ============================================================================
module sync_r2w #(
    parameter int ASIZE = 4
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic [ASIZE:0]   rptr,
    output logic [ASIZE:0]   wq2_rptr
);

    logic [ASIZE:0] r_wq1_rptr;
    logic [ASIZE:0] r_wq2_rptr;

    // rptr is Gray coded, so at most one bit is in flight per change and the
    // first stage may resolve either way without producing a bogus pointer.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wq1_rptr <= '0;
            r_wq2_rptr <= '0;
        end else begin
            r_wq1_rptr <= rptr;
            r_wq2_rptr <= r_wq1_rptr;
        end
    end

    assign wq2_rptr = r_wq2_rptr;

endmodule
`default_nettype wire

// File: rtl/async_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : async_fifo_wr_ctrl
// Description : Write-domain controller of the dual-clock FIFO. Holds the
//               binary/Gray write pointers, qualifies pushes against full,
//               and derives full, almost-full and sticky overflow flags from
//               the synchronized read pointer.
// Ports       : wclk, wrst_n      - write clock, async active-low reset
//               winc              - push request
//               wovf_clr          - clear sticky overflow
//               rptr              - Gray read pointer from the read domain
//               wptr              - registered Gray write pointer
//               waddr             - memory write address
//               wen               - qualified memory write strobe
//               wfull             - FIFO full (registered)
//               walmost_full      - occupancy >= AF_THRESH (registered)
//               woverflow         - sticky push-while-full flag
//               wlevel            - registered occupancy (only when the
//                                   macro ASYNC_FIFO_WLEVEL_EN is defined)
// Revision    : 1.0 - initial release
// ============================================================================
module async_fifo_wr_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ASIZE     = c_DEFAULT_ASIZE,
    parameter int AF_THRESH = 12
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic               winc,
    input  logic               wovf_clr,
    input  logic [ASIZE:0]     rptr,
    output logic [ASIZE:0]     wptr,
    output logic [ASIZE-1:0]   waddr,
    output logic               wen,
    output logic               wfull,
    output logic               walmost_full,
`ifdef ASYNC_FIFO_WLEVEL_EN
    output logic [ASIZE:0]     wlevel,
`endif
    output logic               woverflow
);

    localparam int           c_W  = ASIZE + 1;
    localparam logic [ASIZE:0] c_AF = c_W'(AF_THRESH);

    logic [ASIZE:0] r_wbin;
    logic [ASIZE:0] r_wptr;
    logic           r_wfull;
    logic           r_walmost_full;
    logic           r_woverflow;

    logic [ASIZE:0] w_wq2_rptr;
    logic           w_wen;
    logic [ASIZE:0] w_wbin_next;
    logic [ASIZE:0] w_wgnext;
    logic [ASIZE:0] w_full_match;
    logic [ASIZE:0] w_rbin_s;
    logic [ASIZE:0] w_lvl_next;

    sync_r2w #(
        .ASIZE    (ASIZE)
    ) u_sync_r2w (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .rptr     (rptr),
        .wq2_rptr (w_wq2_rptr)
    );

    assign w_wen       = winc & ~r_wfull;
    assign w_wbin_next = r_wbin + c_W'(w_wen);
    assign w_wgnext    = c_W'(bin2gray(c_MAX_W'(w_wbin_next)));

    // Full when the write pointer has lapped the read pointer exactly once:
    // in Gray code that means the top two bits inverted, the rest equal.
    assign w_full_match = {~w_wq2_rptr[ASIZE:ASIZE-1], w_wq2_rptr[ASIZE-2:0]};

    // The synchronized read pointer is stale, so this level can only
    // over-report occupancy, which is the safe direction for almost-full.
    assign w_rbin_s   = c_W'(gray2bin(c_MAX_W'(w_wq2_rptr)));
    assign w_lvl_next = w_wbin_next - w_rbin_s;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_woverflow    <= 1'b0;
        end else begin
            r_wbin         <= w_wbin_next;
            r_wptr         <= w_wgnext;
            r_wfull        <= (w_wgnext == w_full_match);
            r_walmost_full <= (w_lvl_next >= c_AF);
            // A new overflow in the same cycle as a clear keeps the flag set.
            if (winc & r_wfull) begin
                r_woverflow <= 1'b1;
            end else if (wovf_clr) begin
                r_woverflow <= 1'b0;
            end
        end
    end

`ifdef ASYNC_FIFO_WLEVEL_EN
    logic [ASIZE:0] r_wlevel;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wlevel <= '0;
        end else begin
            r_wlevel <= w_lvl_next;
        end
    end

    assign wlevel = r_wlevel;
`endif

    assign wptr         = r_wptr;
    assign waddr        = r_wbin[ASIZE-1:0];
    assign wen          = w_wen;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign woverflow    = r_woverflow;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_async_fifo_wr_ctrl
// Description : Self-checking bench for async_fifo_wr_ctrl (ASIZE=4,
//               AF_THRESH=12): vector table for fill/overflow/release,
//               count-based model with expected-write queue for streaming
//               wrap-around, hand sequences for mid-operation reset and the
//               optional occupancy output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_async_fifo_wr_ctrl;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic       wovf_clr;
    logic [4:0] rptr;
    logic [4:0] wptr;
    logic [3:0] waddr;
    logic       wen;
    logic       wfull;
    logic       walmost_full;
    logic       woverflow;
`ifdef ASYNC_FIFO_WLEVEL_EN
    logic [4:0] wlevel;
`endif

    int checks = 0;
    int errors = 0;

    async_fifo_wr_ctrl #(
        .ASIZE        (4),
        .AF_THRESH    (12)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wovf_clr     (wovf_clr),
        .rptr         (rptr),
        .wptr         (wptr),
        .waddr        (waddr),
        .wen          (wen),
        .wfull        (wfull),
        .walmost_full (walmost_full),
`ifdef ASYNC_FIFO_WLEVEL_EN
        .wlevel       (wlevel),
`endif
        .woverflow    (woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic       winc;
        logic       clr;
        logic [4:0] rptr;
        logic       e_wen;
        logic [3:0] e_waddr;
        logic [4:0] e_wptr;
        logic       e_full;
        logic       e_af;
        logic       e_ovf;
    } vec_t;

    typedef struct {
        logic [3:0] addr;
        logic [4:0] ptr;
    } exp_t;

    vec_t vecs[24];
    exp_t sb_q[$];

    function automatic logic [4:0] gray5(input int x);
        logic [4:0] b;
        b = 5'(x % 32);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Inputs are changed 1 ns after a rising edge; outputs are sampled 1 ns
    // after the edge (registered) or 2 ns after the input change (combinational).
    task automatic edge_wait();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        winc     = 1'b0;
        wovf_clr = 1'b0;
        rptr     = '0;
        wrst_n   = 1'b0;
        edge_wait();
        edge_wait();
        chk("rst_wptr", 32'(wptr), 32'h0);
        chk("rst_waddr", 32'(waddr), 32'h0);
        chk("rst_flags", {29'd0, wfull, walmost_full, woverflow}, 32'h0);
        @(negedge wclk);
        wrst_n = 1'b1;
        edge_wait();
    endtask

    initial begin
        int         m_w, m_r, m_rq1, m_rq2, occ;
        bit         m_full, exp_wen;
        logic [3:0] act_addr;
        logic [4:0] prev_wptr;
        exp_t       e;

        winc = 0; wovf_clr = 0; rptr = '0; wrst_n = 1'b0;

        // ---------------- vector table: fill, overflow, release -------------
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{winc: 1'b1, clr: 1'b0, rptr: 5'b00000, e_wen: 1'b1,
                        e_waddr: 4'(i), e_wptr: gray5(i + 1), e_full: (i == 15),
                        e_af: (i >= 11), e_ovf: 1'b0};
        end
        vecs[16] = '{1'b1, 1'b0, 5'b00000, 1'b0, 4'h0, 5'b11000, 1'b1, 1'b1, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 5'b00000, 1'b0, 4'h0, 5'b11000, 1'b1, 1'b1, 1'b1};
        vecs[18] = '{1'b1, 1'b1, 5'b00000, 1'b0, 4'h0, 5'b11000, 1'b1, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 5'b00000, 1'b0, 4'h0, 5'b11000, 1'b1, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 5'b00001, 1'b0, 4'h0, 5'b11000, 1'b1, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 5'b00001, 1'b0, 4'h0, 5'b11000, 1'b1, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 5'b00001, 1'b0, 4'h0, 5'b11000, 1'b0, 1'b1, 1'b0};
        vecs[23] = '{1'b1, 1'b0, 5'b00001, 1'b1, 4'h0, 5'b11001, 1'b1, 1'b1, 1'b0};

        do_reset();
        for (int i = 0; i < 24; i++) begin
            winc     = vecs[i].winc;
            wovf_clr = vecs[i].clr;
            rptr     = vecs[i].rptr;
            #2;
            chk($sformatf("v%0d_wen", i), 32'(wen), 32'(vecs[i].e_wen));
            if (vecs[i].e_wen) chk($sformatf("v%0d_waddr", i), 32'(waddr), 32'(vecs[i].e_waddr));
            edge_wait();
            chk($sformatf("v%0d_wptr", i), 32'(wptr), 32'(vecs[i].e_wptr));
            chk($sformatf("v%0d_wfull", i), 32'(wfull), 32'(vecs[i].e_full));
            chk($sformatf("v%0d_walmost_full", i), 32'(walmost_full), 32'(vecs[i].e_af));
            chk($sformatf("v%0d_woverflow", i), 32'(woverflow), 32'(vecs[i].e_ovf));
        end
        winc = 0; wovf_clr = 0;

        // ---------------- streaming wrap with trailing reader ---------------
        do_reset();
        m_w = 0; m_r = 0; m_rq1 = 0; m_rq2 = 0; m_full = 0;
        for (int n = 0; n < 70; n++) begin
            winc = 1'b1;
            rptr = gray5(m_r);
            #2;
            exp_wen = !m_full;
            chk("str_wen", 32'(wen), 32'(exp_wen));
            if (exp_wen) sb_q.push_back('{addr: 4'(m_w % 16), ptr: gray5(m_w + 1)});
            act_addr  = waddr;
            prev_wptr = wptr;
            edge_wait();
            if (exp_wen) m_w++;
            occ    = m_w - m_rq2;
            m_full = (occ == 16);
            m_rq2  = m_rq1;
            m_rq1  = m_r;
            if (exp_wen) begin
                if (sb_q.size() == 0) begin
                    chk("str_queue_empty", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("str_waddr", 32'(act_addr), 32'(e.addr));
                    chk("str_wptr", 32'(wptr), 32'(e.ptr));
                    chk("str_gray_step", $countones(prev_wptr ^ wptr), 32'd1);
                end
            end
            chk("str_wfull", 32'(wfull), 32'(m_full));
            chk("str_walmost_full", 32'(walmost_full), 32'(occ >= 12));
            m_r = (m_w > 4) ? m_w - 4 : 0;
        end
        chk("str_total_writes", 32'(m_w), 32'd70);
        winc = 1'b0;

        // ---------------- reset mid-operation -------------------------------
        do_reset();
        winc = 1'b1;
        for (int n = 0; n < 9; n++) edge_wait();
        winc = 1'b0;
        chk("mid_pre_wptr", 32'(wptr), 32'(gray5(9)));
        #2;
        wrst_n = 1'b0;
        #1;
        chk("mid_rst_wptr", 32'(wptr), 32'h0);
        chk("mid_rst_waddr", 32'(waddr), 32'h0);
        chk("mid_rst_flags", {29'd0, wfull, walmost_full, woverflow}, 32'h0);
        @(negedge wclk);
        wrst_n = 1'b1;
        edge_wait();
        winc = 1'b1;
        #2;
        chk("mid_post_wen", 32'(wen), 32'd1);
        chk("mid_post_waddr", 32'(waddr), 32'h0);
        edge_wait();
        winc = 1'b0;
        chk("mid_post_wptr", 32'(wptr), 32'(gray5(1)));

`ifdef ASYNC_FIFO_WLEVEL_EN
        // ---------------- debug occupancy output ----------------------------
        do_reset();
        winc = 1'b1;
        for (int n = 0; n < 5; n++) edge_wait();
        winc = 1'b0;
        chk("lvl_after_5", 32'(wlevel), 32'd5);
        rptr = gray5(3);
        edge_wait();
        edge_wait();
        chk("lvl_edge2", 32'(wlevel), 32'd5);
        edge_wait();
        chk("lvl_edge3", 32'(wlevel), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
